// File: rtl/hdmi_data_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_data_decoder
// Description : Receive-side HDMI data island packet decoder. Reassembles
//               32-clock packets (24-bit header + four 56-bit subpackets)
//               from TERC4-decoded channel nibbles. Optionally checks the
//               BCH ECC of each stream. Publishes every packet, extracts
//               ACR CTS/N values and walks audio sample packets to emit
//               16-bit L/R samples.
// Option      : `define HDMI_DEC_ECC_EN builds the LFSR syndrome checkers.
//               Without it, every packet is trusted (ok flags forced high).
// Ports       : i_pixclk/i_rst_n   clock, asynchronous active-low reset
//               i_data             data island active
//               i_d0/i_d1/i_d2     channel 0/1/2 nibbles
//               o_hdr, o_sp0..3    last packet header / subpackets
//               o_hdr_ok, o_sp_ok  ECC syndrome-zero flags
//               o_pkt_valid        packet publish pulse
//               o_cts, o_n         last accepted ACR values, o_acr_valid pulse
//               o_audioL/R         audio sample, o_audio_valid pulse
//               o_hsync, o_vsync   syncs sampled during islands
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_data_decoder #(
    parameter int unsigned MAX_SAMPLES    = 4,
    parameter logic [7:0]  AUDIO_PKT_TYPE = 8'h02,
    parameter logic [7:0]  ACR_PKT_TYPE   = 8'h01
) (
    input  logic        i_pixclk,
    input  logic        i_rst_n,
    input  logic        i_data,
    input  logic [3:0]  i_d0,
    input  logic [3:0]  i_d1,
    input  logic [3:0]  i_d2,
    output logic [23:0] o_hdr,
    output logic [55:0] o_sp0,
    output logic [55:0] o_sp1,
    output logic [55:0] o_sp2,
    output logic [55:0] o_sp3,
    output logic        o_hdr_ok,
    output logic [3:0]  o_sp_ok,
    output logic        o_pkt_valid,
    output logic [19:0] o_cts,
    output logic [19:0] o_n,
    output logic        o_acr_valid,
    output logic [15:0] o_audioL,
    output logic [15:0] o_audioR,
    output logic        o_audio_valid,
    output logic        o_hsync,
    output logic        o_vsync
);

    localparam logic [1:0] c_last_k = 2'(MAX_SAMPLES - 1);

    // ------------------------------------------------------------------
    // Bit position. r_cnt holds the index expected for the next island
    // clock; a low i_d0[3] forces the current clock to index 0 (resync).
    // ------------------------------------------------------------------
    logic [4:0]        r_cnt;
    logic [4:0]        w_idx;
    logic              w_last;
    logic [23:0]       r_hdr_sh;
    logic [3:0][55:0]  r_sp_sh;
    logic              w_hdr_ok;
    logic [3:0]        w_sp_ok;

    assign w_idx  = i_d0[3] ? r_cnt : 5'd0;
    assign w_last = i_data && (w_idx == 5'd31);

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 5'd0;
        end else if (i_data) begin
            r_cnt <= w_idx + 5'd1;   // 31 wraps to 0: back-to-back packets
        end else begin
            r_cnt <= 5'd0;           // island ended: any partial packet is dropped
        end
    end

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hdr_sh <= '0;
            r_sp_sh  <= '0;
        end else if (i_data) begin
            if (w_idx < 5'd24) begin
                r_hdr_sh[w_idx] <= i_d0[2];
            end
            if (w_idx < 5'd28) begin
                for (int k = 0; k < 4; k++) begin
                    r_sp_sh[k][{w_idx, 1'b0}] <= i_d1[k];
                    r_sp_sh[k][{w_idx, 1'b1}] <= i_d2[k];
                end
            end
        end
    end

`ifdef HDMI_DEC_ECC_EN
    // ------------------------------------------------------------------
    // BCH syndrome LFSRs; the register is bypassed to zero on index 0 so
    // each packet starts clean. Syndrome is judged on the combinational
    // next value at index 31, so it is ready on the publish edge.
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_bch_step(input logic [7:0] code, input logic b);
        return {code[6:0], 1'b0} ^ ((code[7] ^ b) ? 8'hC1 : 8'h00);
    endfunction

    logic [7:0]       r_hdr_code;
    logic [7:0]       w_hdr_code;
    logic [3:0][7:0]  r_sp_code;
    logic [3:0][7:0]  w_sp_code;

    always_comb begin
        w_hdr_code = f_bch_step((w_idx == 5'd0) ? 8'h00 : r_hdr_code, i_d0[2]);
        w_sp_code  = '0;
        for (int k = 0; k < 4; k++) begin
            w_sp_code[k] = f_bch_step(f_bch_step((w_idx == 5'd0) ? 8'h00 : r_sp_code[k],
                                                 i_d1[k]), i_d2[k]);
        end
    end

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hdr_code <= 8'h00;
            r_sp_code  <= '0;
        end else if (i_data) begin
            r_hdr_code <= w_hdr_code;
            r_sp_code  <= w_sp_code;
        end
    end

    assign w_hdr_ok = (w_hdr_code == 8'h00);
    always_comb begin
        w_sp_ok = 4'h0;
        for (int k = 0; k < 4; k++) begin
            w_sp_ok[k] = (w_sp_code[k] == 8'h00);
        end
    end
`else
    assign w_hdr_ok = 1'b1;
    assign w_sp_ok  = 4'hF;
`endif

    // ------------------------------------------------------------------
    // Packet publish and island sync capture
    // ------------------------------------------------------------------
    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hdr       <= '0;
            o_sp0       <= '0;
            o_sp1       <= '0;
            o_sp2       <= '0;
            o_sp3       <= '0;
            o_hdr_ok    <= 1'b0;
            o_sp_ok     <= 4'h0;
            o_pkt_valid <= 1'b0;
            o_hsync     <= 1'b0;
            o_vsync     <= 1'b0;
        end else begin
            o_pkt_valid <= w_last;
            if (w_last) begin
                o_hdr    <= r_hdr_sh;
                o_sp0    <= r_sp_sh[0];
                o_sp1    <= r_sp_sh[1];
                o_sp2    <= r_sp_sh[2];
                o_sp3    <= r_sp_sh[3];
                o_hdr_ok <= w_hdr_ok;
                o_sp_ok  <= w_sp_ok;
            end
            if (i_data) begin
                o_hsync <= i_d0[0];
                o_vsync <= i_d0[1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Audio clock regeneration
    // ------------------------------------------------------------------
    logic w_acr_go;
    assign w_acr_go = o_pkt_valid && (o_hdr[7:0] == ACR_PKT_TYPE) && o_hdr_ok && o_sp_ok[0];

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cts       <= '0;
            o_n         <= '0;
            o_acr_valid <= 1'b0;
        end else begin
            o_acr_valid <= w_acr_go;
            if (w_acr_go) begin
                o_cts <= {o_sp0[11:8], o_sp0[23:16], o_sp0[31:24]};
                o_n   <= {o_sp0[35:32], o_sp0[47:40], o_sp0[55:48]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Audio sample emitter: one clock per subpacket slot, present or not.
    // Works from the published o_sp* registers, which stay stable for the
    // whole walk because the next packet needs 32 clocks.
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } emit_state_t;

    emit_state_t r_state;
    emit_state_t w_state_nxt;
    logic [1:0]  r_k;
    logic [1:0]  w_k_nxt;
    logic [3:0]  r_mask;
    logic [3:0]  w_mask_nxt;
    logic        w_emit;
    logic        w_audio_go;
    logic [15:0] w_smp_l;
    logic [15:0] w_smp_r;

    assign w_audio_go = o_pkt_valid && (o_hdr[7:0] == AUDIO_PKT_TYPE) && o_hdr_ok;

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_k     <= 2'd0;
            r_mask  <= 4'h0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_mask_nxt  = r_mask;
        w_emit      = 1'b0;
        case (r_state)
            ST_WALK: begin
                w_emit  = r_mask[r_k];
                w_k_nxt = r_k + 2'd1;
                if (r_k == c_last_k) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
            end
        endcase
        if (w_audio_go) begin
            w_state_nxt = ST_WALK;
            w_k_nxt     = 2'd0;
            w_mask_nxt  = o_hdr[11:8] & o_sp_ok;
        end
    end

    always_comb begin
        w_smp_l = o_sp0[23:8];
        w_smp_r = o_sp0[47:32];
        case (r_k)
            2'd1:    begin w_smp_l = o_sp1[23:8]; w_smp_r = o_sp1[47:32]; end
            2'd2:    begin w_smp_l = o_sp2[23:8]; w_smp_r = o_sp2[47:32]; end
            2'd3:    begin w_smp_l = o_sp3[23:8]; w_smp_r = o_sp3[47:32]; end
            default: begin end
        endcase
    end

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_audioL      <= '0;
            o_audioR      <= '0;
            o_audio_valid <= 1'b0;
        end else begin
            o_audio_valid <= w_emit;
            if (w_emit) begin
                o_audioL <= w_smp_l;
                o_audioR <= w_smp_r;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_data_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_data_decoder
// Description : Self-checking bench for hdmi_data_decoder. Builds packets
//               from header/subpacket values with BCH parity, drives them
//               as channel nibbles and checks published packets, ACR and
//               audio outputs against expectation queues every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_data_decoder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        data  = 1'b0;
    logic [3:0]  d0 = '0, d1 = '0, d2 = '0;
    logic [23:0] o_hdr;
    logic [55:0] o_sp0, o_sp1, o_sp2, o_sp3;
    logic        o_hdr_ok, o_pkt_valid, o_acr_valid, o_audio_valid, o_hsync, o_vsync;
    logic [3:0]  o_sp_ok;
    logic [19:0] o_cts, o_n;
    logic [15:0] o_audioL, o_audioR;

    always #5 clk = ~clk;

    hdmi_data_decoder dut (
        .i_pixclk(clk), .i_rst_n(rst_n), .i_data(data),
        .i_d0(d0), .i_d1(d1), .i_d2(d2),
        .o_hdr(o_hdr), .o_sp0(o_sp0), .o_sp1(o_sp1), .o_sp2(o_sp2), .o_sp3(o_sp3),
        .o_hdr_ok(o_hdr_ok), .o_sp_ok(o_sp_ok), .o_pkt_valid(o_pkt_valid),
        .o_cts(o_cts), .o_n(o_n), .o_acr_valid(o_acr_valid),
        .o_audioL(o_audioL), .o_audioR(o_audioR), .o_audio_valid(o_audio_valid),
        .o_hsync(o_hsync), .o_vsync(o_vsync)
    );

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    endfunction

    typedef struct {
        int              cyc;
        logic [23:0]     hdr;
        logic [3:0][55:0] sp;
        logic            hok;
        logic [3:0]      sok;
    } pkt_t;
    typedef struct { int cyc; logic [19:0] cts; logic [19:0] n; } acr_t;
    typedef struct { int deadline; logic [15:0] l; logic [15:0] r; } aud_t;

    pkt_t pq[$];
    acr_t aq[$];
    aud_t uq[$];
    logic m_hs = 1'b0, m_vs = 1'b0;

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        cyc++;
        begin
            logic exp_pv, exp_av;
            exp_pv = (pq.size() > 0) && (pq[0].cyc == cyc);
            chk("pkt_valid", o_pkt_valid, exp_pv);
            if (exp_pv) begin
                chk("hdr", o_hdr, pq[0].hdr);
                chk("sp0", o_sp0, pq[0].sp[0]);
                chk("sp1", o_sp1, pq[0].sp[1]);
                chk("sp2", o_sp2, pq[0].sp[2]);
                chk("sp3", o_sp3, pq[0].sp[3]);
                chk("hdr_ok", o_hdr_ok, pq[0].hok);
                chk("sp_ok", o_sp_ok, pq[0].sok);
                void'(pq.pop_front());
            end
            exp_av = (aq.size() > 0) && (aq[0].cyc == cyc);
            chk("acr_valid", o_acr_valid, exp_av);
            if (exp_av) begin
                chk("cts", o_cts, aq[0].cts);
                chk("n", o_n, aq[0].n);
                void'(aq.pop_front());
            end
        end
        if (o_audio_valid) begin
            if (uq.size() == 0) begin
                total++;
                $display("FAIL audio_unexpected: got pulse L=%h R=%h, required none", o_audioL, o_audioR);
            end else begin
                chk("audioL", o_audioL, uq[0].l);
                chk("audioR", o_audioR, uq[0].r);
                void'(uq.pop_front());
            end
        end
        if (uq.size() > 0 && uq[0].deadline < cyc) begin
            total++;
            $display("FAIL audio_missing: got no pulse, required L=%h R=%h", uq[0].l, uq[0].r);
            void'(uq.pop_front());
        end
        chk("hsync", o_hsync, m_hs);
        chk("vsync", o_vsync, m_vs);
    end

    // ---------------- packet construction ----------------
    function automatic logic [7:0] bch(input logic [63:0] bits, input int nbits);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < nbits; i++)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ bits[i]) ? 8'hC1 : 8'h00);
        return c;
    endfunction

    function automatic logic [55:0] make_acr(input logic [19:0] cts, input logic [19:0] n);
        logic [55:0] s;
        s = '0;
        s[11:8]  = cts[19:16]; s[23:16] = cts[15:8]; s[31:24] = cts[7:0];
        s[35:32] = n[19:16];   s[47:40] = n[15:8];   s[55:48] = n[7:0];
        return s;
    endfunction

    function automatic logic [55:0] make_aud(input logic [15:0] l, input logic [15:0] r);
        logic [55:0] s;
        s = '0;
        s[7:0] = 8'h5A; s[23:8] = l; s[31:24] = 8'hC3; s[47:32] = r; s[55:48] = 8'h3C;
        return s;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data = 1'b0; d0 = '0; d1 = '0; d2 = '0;
        end
    endtask

    // Drives n_clk nibbles (32 = full packet). bad_k >= 0 flips data bit
    // bad_bit of subpacket bad_k after parity has been computed.
    task automatic send_packet(input logic [23:0] hdr, input logic [3:0][55:0] sp,
                               input bit first, input int bad_k, input int bad_bit,
                               input int n_clk);
        logic [31:0]      hs;
        logic [63:0]      ss [4];
        logic [7:0]       r;
        logic [3:0][55:0] rx;
        logic [3:0]       sok;
        logic [3:0]       mask;
        pkt_t p;
        acr_t a;
        aud_t u;
        hs = {8'h00, hdr};
        r  = bch({40'h0, hdr}, 24);
        for (int i = 0; i < 8; i++) hs[24 + i] = r[7 - i];
        for (int k = 0; k < 4; k++) begin
            ss[k] = {8'h00, sp[k]};
            r = bch(ss[k], 56);
            for (int i = 0; i < 8; i++) ss[k][56 + i] = r[7 - i];
        end
        rx  = sp;
        sok = 4'hF;
        if (bad_k >= 0) begin
            ss[bad_k][bad_bit] = ~ss[bad_k][bad_bit];
            rx[bad_k][bad_bit] = ~rx[bad_k][bad_bit];
`ifdef HDMI_DEC_ECC_EN
            sok[bad_k] = 1'b0;
`endif
        end
        for (int c = 0; c < n_clk; c++) begin
            @(negedge clk);
            data  = 1'b1;
            d0[3] = !(first && c == 0);
            d0[2] = hs[c];
            d0[1] = c[3];
            d0[0] = c[0];
            for (int k = 0; k < 4; k++) begin
                d1[k] = ss[k][2 * c];
                d2[k] = ss[k][2 * c + 1];
            end
            m_hs = c[0];
            m_vs = c[3];
            if (c == 31) begin
                p.cyc = cyc + 1; p.hdr = hdr; p.sp = rx; p.hok = 1'b1; p.sok = sok;
                pq.push_back(p);
                if (hdr[7:0] == 8'h01 && sok[0]) begin
                    a.cyc = cyc + 2;
                    a.cts = {rx[0][11:8], rx[0][23:16], rx[0][31:24]};
                    a.n   = {rx[0][35:32], rx[0][47:40], rx[0][55:48]};
                    aq.push_back(a);
                end
                if (hdr[7:0] == 8'h02) begin
                    mask = hdr[11:8] & sok;
                    for (int k = 0; k < 4; k++) begin
                        if (mask[k]) begin
                            u.deadline = cyc + 9;
                            u.l = rx[k][23:8];
                            u.r = rx[k][47:32];
                            uq.push_back(u);
                        end
                    end
                end
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    logic [3:0][55:0] sp_acr, sp_aud1, sp_aud4, sp_avi;

    initial begin
        for (int k = 0; k < 4; k++) sp_acr[k] = make_acr(20'd27000, 20'd6144);
        sp_aud1 = '0;
        sp_aud1[0] = make_aud(16'h1234, 16'hABCD);
        sp_aud4[0] = make_aud(16'h1111, 16'h2222);
        sp_aud4[1] = make_aud(16'h3333, 16'h4444);
        sp_aud4[2] = make_aud(16'h5555, 16'h6666);
        sp_aud4[3] = make_aud(16'h7777, 16'h8888);
        sp_avi[0] = 56'h00_1122_3344_5566;
        sp_avi[1] = 56'h77_8899_AABB_CCDD;
        sp_avi[2] = 56'h0F_0E0D_0C0B_0A09;
        sp_avi[3] = 56'hF0_E0D0_C0B0_A090;

        // reset state
        idle(3);
        chk("rst_hdr", o_hdr, 24'h0);
        chk("rst_pkt_valid", o_pkt_valid, 1'b0);
        chk("rst_sp_ok", o_sp_ok, 4'h0);
        chk("rst_cts", o_cts, 20'h0);
        chk("rst_audio_valid", o_audio_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // ACR packet
        send_packet(24'h000001, sp_acr, 1'b1, -1, 0, 32);
        idle(4);
        chk("lit_cts", o_cts, 20'd27000);
        chk("lit_n", o_n, 20'd6144);

        // single-sample audio packet
        send_packet(24'h100102, sp_aud1, 1'b1, -1, 0, 32);
        idle(10);
        chk("lit_audioL", o_audioL, 16'h1234);
        chk("lit_audioR", o_audioR, 16'hABCD);

        // back-to-back AVI then 4-sample audio
        send_packet(24'h0D0282, sp_avi, 1'b1, -1, 0, 32);
        send_packet(24'h000F02, sp_aud4, 1'b0, -1, 0, 32);
        idle(10);
        chk("lit_b2b_audioL", o_audioL, 16'h7777);

        // corrupted sp2 data bit
        send_packet(24'h000F02, sp_aud4, 1'b1, 2, 20, 32);
        idle(10);
`ifdef HDMI_DEC_ECC_EN
        chk("lit_bad_sp_ok", o_sp_ok, 4'b1011);
`else
        chk("lit_bad_sp_ok", o_sp_ok, 4'hF);
`endif
        chk("lit_bad_hdr_ok", o_hdr_ok, 1'b1);

        // island drop mid-packet, then a clean packet
        send_packet(24'h000001, sp_acr, 1'b1, -1, 0, 16);
        idle(3);
        send_packet(24'h100102, sp_aud1, 1'b1, -1, 0, 32);
        idle(10);

        // resync: partial packet interrupted by a new first-clock marker
        send_packet(24'h0D0282, sp_avi, 1'b1, -1, 0, 10);
        send_packet(24'h000001, sp_acr, 1'b1, -1, 0, 32);
        idle(6);

        // asynchronous reset mid-packet
        send_packet(24'h0D0282, sp_avi, 1'b1, -1, 0, 21);
        @(negedge clk);
        rst_n = 1'b0; data = 1'b0; m_hs = 1'b0; m_vs = 1'b0;
        #1;
        chk("rstmid_hdr", o_hdr, 24'h0);
        chk("rstmid_sp0", o_sp0, 56'h0);
        chk("rstmid_cts", o_cts, 20'h0);
        chk("rstmid_n", o_n, 20'h0);
        chk("rstmid_audioL", o_audioL, 16'h0);
        chk("rstmid_hdr_ok", o_hdr_ok, 1'b0);
        idle(3);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_packet(24'h000001, sp_acr, 1'b1, -1, 0, 32);
        idle(5);
        chk("lit_post_rst_cts", o_cts, 20'd27000);

        idle(12);
        chk("pkt_queue_drained", pq.size(), 0);
        chk("acr_queue_drained", aq.size(), 0);
        chk("audio_queue_drained", uq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hdmi_data_decoder.md
Name: hdmi_data_decoder

Overview:
Receive-side counterpart of the HDMI data island packet encoder. It takes TERC4-decoded 4-bit nibbles for channels 0/1/2 during data island periods and reassembles 32-clock packets (24-bit header and four 56-bit subpackets). It checks BCH ECC and publishes each packet. It also extracts audio clock regeneration values (CTS/N) and 16-bit L/R audio samples for the HDMI sink audio path.

Parameters:
- MAX_SAMPLES, 4, number of subpackets scanned for audio samples per audio sample packet (1..4).
- AUDIO_PKT_TYPE, 8'h02, header byte HB0 that marks an audio sample packet.
- ACR_PKT_TYPE, 8'h01, header byte HB0 that marks an audio clock regeneration packet.

Ports:
- i_pixclk in 1 pixel clock; all logic on rising edge.
- i_rst_n in 1 asynchronous active-low reset.
- i_data in 1 high while the data island is active; nibbles are valid.
- i_d0 in 4 ch0 nibble: [0]=hsync, [1]=vsync, [2]=header bit, [3]=0 only on the first clock of an island's first packet.
- i_d1 in 4 ch1 nibble: bit k = even bit of subpacket k.
- i_d2 in 4 ch2 nibble: bit k = odd bit of subpacket k.
- o_hdr out 24 last packet header (HB0 in [7:0]).
- o_sp0..o_sp3 out 56 each; last packet subpackets (SB0 in [7:0]).
- o_hdr_ok out 1 header ECC syndrome zero.
- o_sp_ok out 4 per-subpacket ECC syndrome zero.
- o_pkt_valid out 1 one-cycle pulse; o_hdr/o_sp*/ok flags are updated.
- o_cts out 20 last accepted ACR CTS.
- o_n out 20 last accepted ACR N.
- o_acr_valid out 1 one-cycle pulse on o_cts/o_n update.
- o_audioL out 16 audio sample, left.
- o_audioR out 16 audio sample, right.
- o_audio_valid out 1 one-cycle pulse per sample.
- o_hsync out 1 hsync sampled from i_d0[0] during islands.
- o_vsync out 1 vsync sampled from i_d0[1] during islands.

Behaviour:
- Reset values: all outputs 0; bit counter 0; ECC registers 0; sample emitter IDLE.
- Bit counter cnt 0..31 advances each clock while i_data=1.
  - Restarts at 0 when i_data rises.
  - If i_d0[3]=0 while cnt!=0: resync. This clock becomes cnt=0 and the partial packet is discarded.
  - If i_data falls with cnt!=0: discard the partial packet, cnt=0, no o_pkt_valid.
- Header: cnt 0..23 shift i_d0[2] into hdr bit cnt (LSB first); cnt 24..31 are parity.
- Subpacket k: cnt 0..27 load bits 2*cnt (i_d1[k]) and 2*cnt+1 (i_d2[k]); cnt 28..31 are parity.
- ECC: per stream, 8-bit LFSR, reset to 0 at cnt=0. Per bit b: code = (code<<1) ^ ((code[7]^b) ? 8'hC1 : 0).
  - All bits, parity included, are fed in order; subpackets take the even bit before the odd bit each clock.
  - ok = (code==0) after cnt=31.
- Latency: o_pkt_valid pulses on the clock after the cnt=31 sample. o_hdr, o_sp*, o_hdr_ok and o_sp_ok update on that same edge.
- Back-to-back packets: cnt wraps 31→0 with no gap clock. The next packet's first bit is sampled on the wrap clock.
- ACR: when o_pkt_valid, HB0==ACR_PKT_TYPE and both hdr and sp0 are ok, then on the next clock:
  - o_cts = {sp0[11:8], sp0[23:16], sp0[31:24]}
  - o_n = {sp0[35:32], sp0[47:40], sp0[55:48]}
  - o_acr_valid pulses.
- Audio: when o_pkt_valid, HB0==AUDIO_PKT_TYPE and hdr is ok, latch the present mask = hdr[11:8] & sp_ok.
  - Emitter walks k=0..MAX_SAMPLES-1, one clock per k.
  - For each present k: o_audioL = sp_k[23:8], o_audioR = sp_k[47:32], o_audio_valid pulses.
  - Absent k still costs one clock. The walk completes within 4 clocks, well before the next packet completes.
- Bad ECC or other HB0 values: packet is still published via o_pkt_valid with its ok flags; no ACR or audio outputs.
- o_hsync/o_vsync register i_d0[0]/[1] each clock i_data=1 and hold otherwise.
- Async reset mid-packet or mid-walk: everything clears immediately; no pulse is issued.

Optional Feature:
HDMI_DEC_ECC_EN.
- Defined: LFSR checkers are built and o_hdr_ok/o_sp_ok reflect the syndromes as above.
- Undefined: no ECC logic; o_hdr_ok=1 and o_sp_ok=4'hF whenever o_pkt_valid, and every packet is trusted.

Test Plan:
- ACR packet, hdr 24'h000001, sp0..3 = {N=6144, CTS=27000} encoded with correct BCH → o_pkt_valid; next clock o_cts=20'd27000, o_n=20'd6144, o_acr_valid=1.
- Audio packet, hdr 24'h100102, sp0 = L 0x1234 / R 0xABCD → one o_audio_valid pulse with o_audioL=16'h1234, o_audioR=16'hABCD.
- Two back-to-back packets (AVI 24'h0D0282, then audio with 4 samples present) → two o_pkt_valid pulses 32 clocks apart; 4 audio pulses in order k=0..3.
- Flip one sp2 data bit → o_sp_ok=4'b1011, o_hdr_ok=1; the sp2 sample is dropped and the other samples emit (macro defined).
- i_data drops at cnt=15 → no o_pkt_valid. The next island packet decodes correctly.
- Assert i_rst_n=0 at cnt=20 → all outputs 0 immediately. After release, a fresh ACR packet decodes with o_cts=27000.
